// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Each operation takes 32 iterations: a shift-add multiplier or a restoring divider
// working on operand magnitudes, with the sign applied when the result is registered.
// The divider datapath is compiled in only when MULDIV_DIV_EN is defined. Without it,
// ops 1xx keep the same handshake and latency and return zero.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned PROD_W = 2 * XLEN;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned OP_W   = 3;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    localparam logic [OP_W-1:0] OP_MULH   = 3'b001;
    localparam logic [OP_W-1:0] OP_MULHSU = 3'b010;
    localparam logic [OP_W-1:0] OP_DIV    = 3'b100;
    localparam logic [OP_W-1:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_accept;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    logic [CNT_W-1:0]  r_cnt;
    logic [OP_W-1:0]   r_op;
    logic [XLEN-1:0]   r_hi;      // product high half / partial remainder
    logic [XLEN-1:0]   r_lo;      // multiplier (shifting out) / dividend-quotient
    logic [XLEN-1:0]   r_opnd;    // multiplicand / divisor magnitude
    logic              r_neg;     // negate product or quotient at the end

    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;

    logic [XLEN:0]     w_mul_sum;
    logic [XLEN-1:0]   w_mul_hi_nx;
    logic [XLEN-1:0]   w_mul_lo_nx;
    logic [PROD_W-1:0] w_prod;
    logic [PROD_W-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_mul_res;

    logic [XLEN-1:0]   w_hi_nx;
    logic [XLEN-1:0]   w_lo_nx;
    logic [XLEN-1:0]   w_res_fin;

`ifdef MULDIV_DIV_EN
    logic              r_neg_rem;
    logic              r_b_zero;
    logic [XLEN-1:0]   r_a_raw;

    logic [XLEN:0]     w_div_shift;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_div_diff;
    logic [XLEN-1:0]   w_div_hi_nx;
    logic [XLEN-1:0]   w_div_lo_nx;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
`endif

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

    // Next-state decode; start is only taken in IDLE or DONE
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == LAST_ITER) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_BUSY;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register with status flags registered from the next state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == S_BUSY);
            r_done  <= (w_state_next == S_DONE);
        end
    end

    // Operand sign classification and magnitude conversion at capture
    always_comb begin
        w_a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        w_b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        w_a_neg    = w_a_signed & a[XLEN-1];
        w_b_neg    = w_b_signed & b[XLEN-1];
        w_a_mag    = w_a_neg ? (~a + XLEN'(1)) : a;
        w_b_mag    = w_b_neg ? (~b + XLEN'(1)) : b;
    end

    // One shift-add multiply step and the signed 64-bit product it would finish with
    always_comb begin
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
        w_mul_hi_nx = w_mul_sum[XLEN:1];
        w_mul_lo_nx = {w_mul_sum[0], r_lo[XLEN-1:1]};
        w_prod      = {w_mul_hi_nx, w_mul_lo_nx};
        w_prod_fix  = r_neg ? (~w_prod + PROD_W'(1)) : w_prod;
        w_mul_res   = (r_op[1:0] == 2'b00) ? w_prod_fix[XLEN-1:0] : w_prod_fix[PROD_W-1:XLEN];
    end

`ifdef MULDIV_DIV_EN
    // One restoring divide step and the signed quotient/remainder it would finish with
    always_comb begin
        w_div_shift = {r_hi, r_lo[XLEN-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
        w_div_diff  = w_div_shift[XLEN-1:0] - r_opnd;
        w_div_hi_nx = w_div_ge ? w_div_diff : w_div_shift[XLEN-1:0];
        w_div_lo_nx = {r_lo[XLEN-2:0], w_div_ge};
        w_quo_fix   = r_neg ? (~w_div_lo_nx + XLEN'(1)) : w_div_lo_nx;
        w_rem_fix   = r_neg_rem ? (~w_div_hi_nx + XLEN'(1)) : w_div_hi_nx;
    end

    // Step and final-result selection between multiplier and divider
    always_comb begin
        w_hi_nx   = r_op[2] ? w_div_hi_nx : w_mul_hi_nx;
        w_lo_nx   = r_op[2] ? w_div_lo_nx : w_mul_lo_nx;
        w_res_fin = w_mul_res;
        if (r_op[2]) begin
            if (r_op[1]) begin
                w_res_fin = r_b_zero ? r_a_raw : w_rem_fix;
            end else begin
                w_res_fin = r_b_zero ? {XLEN{1'b1}} : w_quo_fix;
            end
        end
    end
`else
    // Step and final-result selection; ops 1xx return zero without a divider
    always_comb begin
        w_hi_nx   = w_mul_hi_nx;
        w_lo_nx   = w_mul_lo_nx;
        w_res_fin = r_op[2] ? {XLEN{1'b0}} : w_mul_res;
    end
`endif

    // Operand capture, per-cycle iteration and result register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_op      <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_opnd    <= '0;
            r_neg     <= 1'b0;
            r_result  <= '0;
`ifdef MULDIV_DIV_EN
            r_neg_rem <= 1'b0;
            r_b_zero  <= 1'b0;
            r_a_raw   <= '0;
`endif
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_op      <= op;
            r_hi      <= '0;
            r_lo      <= w_a_mag;
            r_opnd    <= w_b_mag;
            r_neg     <= w_a_neg ^ w_b_neg;
`ifdef MULDIV_DIV_EN
            r_neg_rem <= w_a_neg;
            r_b_zero  <= (b == '0);
            r_a_raw   <= a;
`endif
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_hi  <= w_hi_nx;
            r_lo  <= w_lo_nx;
            if (r_cnt == LAST_ITER) begin
                r_result <= w_res_fin;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit.
// Expected results and completion cycles are queued when a start is driven and
// popped by a monitor when done pulses.
module tb_muldiv_unit;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    muldiv_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done cyc=%0d result=%h required=no done pulse", cyc, result);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (result !== mon_e.res) begin
                    failures++;
                    $display("FAIL result cyc=%0d got=%h want=%h", cyc, result, mon_e.res);
                end
                checks++;
                if (cyc != mon_e.due) begin
                    failures++;
                    $display("FAIL latency done_cyc=%0d want_cyc=%0d", cyc, mon_e.due);
                end
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_with_done got=%b want=0", busy);
                end
            end
        end
    end

    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
        longint          p;
        longint unsigned pu;
        int              sx;
        int              sy;
        logic [31:0]     r;
        sx = x;
        sy = y;
        r  = 32'd0;
        case (o)
            3'b000: begin pu = {32'd0, x} * {32'd0, y}; r = pu[31:0]; end
            3'b001: begin p = longint'(sx) * longint'(sy); r = p[63:32]; end
            3'b010: begin p = longint'(sx) * longint'({32'd0, y}); r = p[63:32]; end
            3'b011: begin pu = {32'd0, x} * {32'd0, y}; r = pu[63:32]; end
`ifdef MULDIV_DIV_EN
            3'b100: begin
                if (y == 32'd0) r = 32'hFFFF_FFFF;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = 32'(sx / sy);
            end
            3'b101: r = (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            3'b110: begin
                if (y == 32'd0) r = x;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
                else r = 32'(sx % sy);
            end
            3'b111: r = (y == 32'd0) ? x : x % y;
`endif
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic push_exp(input logic [31:0] res, input int due);
        exp_t t;
        t.res = res;
        t.due = due;
        sb.push_back(t);
    endtask

    // Called at a negedge with the DUT in IDLE or DONE; returns one negedge after acceptance
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] want);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        push_exp(want, cyc + 33);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b1;
        op    = 3'b000;
        a     = 32'd9;
        b     = 32'd9;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++;
        if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h want=0", result); end
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL start_in_reset_busy got=%b want=0", busy); end
    endtask

    task automatic test_mul();
        bit ok;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL mul_timeout got=no done want=done"); end
        repeat (3) @(negedge clk);
        checks++;
        if (result !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_hold got=%h want=ffffffeb", result); end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_flags got=%b%b want=00", busy, done);
        end
    endtask

    task automatic test_mulh();
        bit ok;
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL mulhu_timeout got=no done want=done"); end
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL mulh_timeout got=no done want=done"); end
        issue(3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL mulhsu_timeout got=no done want=done"); end
        @(negedge clk);
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div();
        bit ok;
        logic [2:0]  ops [6] = '{3'b100, 3'b110, 3'b101, 3'b110, 3'b100, 3'b111};
        logic [31:0] xs  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000,
                                 32'h8000_0000, 32'd9};
        logic [31:0] ys  [6] = '{32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] ws  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,
                                 32'h8000_0000, 32'd9};
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], xs[i], ys[i], ws[i]);
            wait_done(ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL div_timeout case=%0d got=no done want=done", i); end
        end
        @(negedge clk);
    endtask
`else
    task automatic test_nodiv();
        bit ok;
        issue(3'b100, 32'd10, 32'd2, 32'd0);
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL nodiv_timeout got=no done want=done"); end
        issue(3'b111, 32'd10, 32'd3, 32'd0);
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL noremu_timeout got=no done want=done"); end
        @(negedge clk);
    endtask
`endif

    task automatic test_start_during_busy();
        bit ok;
        issue(3'b000, 32'd3, 32'd5, 32'd15);
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL busy_mid_op got=%b want=1", busy); end
        op    = 3'b011;
        a     = 32'hFFFF_FFFF;
        b     = 32'hFFFF_FFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL ignored_start_timeout got=no done want=done"); end
        repeat (40) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL ignored_start_pending got=%0d want=0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        push_exp(32'd42, cyc + 33);
        push_exp(32'hFFFF_FFFE, cyc + 66);
        op    = 3'b000;
        a     = 32'd6;
        b     = 32'd7;
        start = 1'b1;
        @(negedge clk);
        op    = 3'b011;
        a     = 32'hFFFF_FFFF;
        b     = 32'hFFFF_FFFF;
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_first_timeout got=no done want=done"); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b want=1", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL b2b_done got=%b want=0", done); end
        start = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_second_timeout got=no done want=done"); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        issue(3'b000, 32'd123, 32'd456, 32'd56088);
        repeat (9) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL pre_abort_busy got=%b want=1", busy); end
        rst = 1'b0;
        @(negedge clk);
        sb.delete();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b want=0", done); end
        checks++;
        if (result !== 32'd0) begin failures++; $display("FAIL abort_result got=%h want=0", result); end
        rst = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (result !== 32'd0) begin failures++; $display("FAIL abort_idle_result got=%h want=0", result); end
    endtask

    task automatic test_random();
        bit          ok;
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        for (int i = 0; i < 16; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = (i % 5 == 0) ? 32'd0 : $urandom;
            issue(o, x, y, ref_result(o, x, y));
            wait_done(ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL random_timeout idx=%0d got=no done want=done", i); end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
`ifdef MULDIV_DIV_EN
        test_div();
`else
        test_nodiv();
`endif
        test_start_during_busy();
        test_back_to_back();
        test_reset_mid_busy();
        test_random();
        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL final_pending got=%0d want=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use a synchronous, active-low reset.
REQ-002 The port `clk` SHALL be an input of width 1 and SHALL be the rising-edge clock.
REQ-003 The port `rst` SHALL be an input of width 1 and SHALL be the synchronous active-low reset: 0 resets the block, 1 lets it run.
REQ-004 The port `start` SHALL be an input of width 1 and SHALL request a new operation.
REQ-005 The port `op` SHALL be an input of width 3 and SHALL carry the RV32M funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The port `a` SHALL be an input of width 32 and SHALL carry operand rs1, taken from Registers ReadData1.
REQ-007 The port `b` SHALL be an input of width 32 and SHALL carry operand rs2, taken from Registers ReadData2.
REQ-008 The port `busy` SHALL be an output of width 1 and SHALL be high while an operation is iterating.
REQ-009 The port `done` SHALL be an output of width 1 and SHALL be a one-cycle pulse meaning `result` is valid.
REQ-010 The port `result` SHALL be an output of width 32 and SHALL be the registered result, downstream to the writeback mux.

Function
REQ-011 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-012 `start` SHALL be accepted on a rising edge only in IDLE or DONE; acceptance SHALL capture `op`, `a` and `b`, clear the 5-bit iteration counter, and enter BUSY.
REQ-013 `start` SHALL be ignored while in BUSY; captured operands SHALL NOT change mid-operation.
REQ-014 BUSY SHALL perform exactly one iteration per cycle, 32 iterations in total, using a shift-add multiplier or a restoring divider on magnitudes.
REQ-015 Latency SHALL be fixed: for a start accepted at edge N, iterations SHALL occur on edges N+1..N+32, the transition to DONE with `result` registered SHALL occur at edge N+32, and `done` SHALL be high in the cycle following edge N+32.
REQ-016 DONE SHALL last exactly one cycle; it SHALL go to BUSY if `start`=1, otherwise to IDLE.
REQ-017 `result` SHALL hold its value until the next DONE, and SHALL NOT change in IDLE.
REQ-018 `busy` SHALL be 1 exactly in BUSY; `done` SHALL be 1 exactly in DONE; `busy` and `done` SHALL never both be 1.
REQ-019 MUL SHALL return product[31:0]; MULH SHALL return signed x signed product[63:32]; MULHSU SHALL return signed a x unsigned b product[63:32]; MULHU SHALL return unsigned product[63:32].
REQ-020 Signed operands SHALL be converted to magnitudes at capture, and the sign SHALL be applied to the final 64-bit product or to the quotient/remainder.
REQ-021 For DIV/DIVU with b=0, the quotient SHALL be 32'hFFFF_FFFF; for REM/REMU with b=0, the remainder SHALL be `a`.
REQ-022 For DIV with a=32'h8000_0000 and b=32'hFFFF_FFFF, the quotient SHALL be 32'h8000_0000; for the same REM case, the remainder SHALL be 0.
REQ-023 The remainder sign SHALL follow the dividend; the quotient SHALL truncate toward zero.
REQ-024 Special cases SHALL keep the same 32-cycle latency.

Reset
REQ-025 When `rst`=0 at a rising edge, the block SHALL enter IDLE with `busy`=0, `done`=0, `result`=32'h0, the counter at 0, and operand registers at 0.
REQ-026 A reset mid-BUSY SHALL abort the operation; no `done` SHALL follow.
REQ-027 `start` SHALL be ignored during any edge where `rst`=0.

Configuration
REQ-028 When the macro MULDIV_DIV_EN is defined, the divider datapath SHALL be compiled in and ops 100-111 SHALL behave per REQ-021..REQ-023.
REQ-029 When MULDIV_DIV_EN is undefined, the divider logic SHALL be absent; ops 1xx SHALL still be accepted, SHALL complete with identical latency and handshake, and SHALL return `result`=32'h0.

Verification
REQ-030 The bench SHALL cover: rst=0 for 2 cycles -> busy=0, done=0, result=0.
REQ-031 The bench SHALL cover: MUL a=7, b=-3 (32'hFFFF_FFFD) with start at edge N -> done at cycle N+32, result=32'hFFFF_FFEB.
REQ-032 The bench SHALL cover: MULHU a=b=32'hFFFF_FFFF -> result=32'hFFFF_FFFE; MULH with the same operands -> result=0.
REQ-033 The bench SHALL cover, with MULDIV_DIV_EN defined: DIV a=-7, b=2 -> result=-3 (32'hFFFF_FFFD); REM with the same operands -> result=-1; DIVU a=5, b=0 -> result=32'hFFFF_FFFF; REM a=32'h8000_0000, b=-1 -> result=0.
REQ-034 The bench SHALL cover: start pulsed again during BUSY -> ignored, single done; start held high in DONE -> back-to-back op with busy=1 on the next cycle.
REQ-035 The bench SHALL cover: rst=0 at iteration 10 -> IDLE next cycle, no done pulse, result=0; and, with MULDIV_DIV_EN undefined, DIV 10/2 -> done after 32 cycles, result=0.
